// File: rtl/serdes_pkg.sv
// Shared definitions for the byte-lane packer/serializer pair: lane geometry,
// FSM state type and nbytes normalisation.
package serdes_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } ser_state_e;

  // Bit offset of the lane emitted at position idx of a word of nbytes lanes.
  function automatic int unsigned lane_offset(input int unsigned idx,
                                              input int unsigned nbytes,
                                              input bit          msb_first);
    return msb_first ? (nbytes - 1 - idx) * BYTE_W : idx * BYTE_W;
  endfunction

  // A lane count of zero or beyond the word width means "whole word".
  function automatic int unsigned norm_nbytes(input int unsigned n,
                                              input int unsigned nbytes);
    return (n == 0 || n > nbytes) ? nbytes : n;
  endfunction

endpackage

// File: rtl/byte_serializer_lane_mux.sv
// Selects one byte lane of a held word by emission index, honouring the
// configured lane order.
module lane_mux
  import serdes_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [BYTE_W-1:0] byte_o
);

  localparam int unsigned NBYTES = WORD_W / BYTE_W;

  logic [BYTE_W-1:0] lanes [NBYTES];

  for (genvar g = 0; g < NBYTES; g++) begin : g_lane
    assign lanes[g] = word_i[lane_offset(g, NBYTES, MSB_FIRST) +: BYTE_W];
  end

  always_comb begin
    byte_o = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_i == IDX_W'(i)) byte_o = lanes[i];
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Word-to-byte unpacker with ready/valid on both sides, selectable lane
// order, partial words and a packet-last marker.
module byte_serializer
  import serdes_pkg::*;
#(
  parameter  int unsigned WORD_W    = 32,
  parameter  bit          MSB_FIRST = 1'b1,
  localparam int unsigned NBYTES    = WORD_W / 8,
  localparam int unsigned CNT_W     = $clog2(NBYTES) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [CNT_W-1:0]  nbytes_i,
  input  logic              last_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic              byte_last_o
);

  if (WORD_W % 8 != 0 || WORD_W < 16) begin : g_bad_width
    $error("byte_serializer: WORD_W must be a multiple of 8 and at least 16");
  end

  ser_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  nb_q;
  logic [CNT_W-1:0]  idx_q;
  logic              last_q;

  logic             load;
  logic             advance;
  logic             is_final;
  logic [CNT_W-1:0] nb_eff;

  assign nb_eff   = CNT_W'(norm_nbytes(32'(nbytes_i), NBYTES));
  assign is_final = (idx_q == nb_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    advance      = 1'b0;
    word_ready_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        word_ready_o = 1'b1;
        if (word_valid_i) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (byte_ready_i) begin
          if (is_final) begin
            // Retiring the last lane frees the holder in the same cycle.
            word_ready_o = 1'b1;
            if (word_valid_i) load    = 1'b1;
            else              state_d = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst_i) begin
      word_ready_o = 1'b0;
      load         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      nb_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        word_q <= word_i;
        nb_q   <= nb_eff;
        last_q <= last_i;
        idx_q  <= '0;
      end else if (advance) begin
        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

  lane_mux #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (CNT_W)
  ) u_lane_mux (
    .word_i (word_q),
    .idx_i  (idx_q),
    .byte_o (byte_o)
  );

  assign byte_valid_o = (state_q == ST_SHIFT);
  assign byte_last_o  = (state_q == ST_SHIFT) && last_q && is_final;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench: one MSB-first and one LSB-first instance share stimulus;
// directed table, corner sequences, then random traffic against a queue model.
module tb_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word;
  logic [2:0]  nbytes;
  logic        last;
  logic        word_valid;
  logic        byte_ready;

  logic       rdy_m, val_m, lst_m, rdy_l, val_l, lst_l;
  logic [7:0] byte_m, byte_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  byte_serializer #(.WORD_W(32), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .word_i(word), .nbytes_i(nbytes), .last_i(last),
    .word_valid_i(word_valid), .word_ready_o(rdy_m), .byte_o(byte_m),
    .byte_valid_o(val_m), .byte_ready_i(byte_ready), .byte_last_o(lst_m));

  byte_serializer #(.WORD_W(32), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .word_i(word), .nbytes_i(nbytes), .last_i(last),
    .word_valid_i(word_valid), .word_ready_o(rdy_l), .byte_o(byte_l),
    .byte_valid_o(val_l), .byte_ready_i(byte_ready), .byte_last_o(lst_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors: expected byte sequences packed first-out in bits [31:24].
  typedef struct {
    logic [31:0] w;
    logic [2:0]  nb;
    logic        lst;
    int          n;
    logic [31:0] exp_m;
    logic [31:0] exp_l;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    logic [31:0] em, el;
    em = v.exp_m;
    el = v.exp_l;
    @(negedge clk);
    word = v.w; nbytes = v.nb; last = v.lst; word_valid = 1'b1; byte_ready = 1'b1;
    #1 chk("vec_ready_idle", {rdy_m, rdy_l}, 2'b11);
    @(negedge clk);
    word_valid = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      #1;
      chk("vec_valid", {val_m, val_l}, 2'b11);
      chk("vec_byte_msb", byte_m, em[31:24]);
      chk("vec_byte_lsb", byte_l, el[31:24]);
      chk("vec_last", {lst_m, lst_l}, {2{v.lst && (k == v.n - 1)}});
      chk("vec_ready", {rdy_m, rdy_l}, {2{k == v.n - 1}});
      em = em << 8;
      el = el << 8;
      @(negedge clk);
    end
    #1 chk("vec_idle_after", {val_m, val_l}, 2'b00);
  endtask

  // Behavioural reference: a word becomes a list of bytes in wire order.
  typedef struct { logic [7:0] d; logic l; } ent_t;
  ent_t q_m[$], q_l[$];

  task automatic model_push(input logic [31:0] w, input logic [2:0] n, input logic l);
    int eff;
    ent_t e;
    eff = (n == 0 || n > 4) ? 4 : int'(n);
    for (int k = 0; k < eff; k++) begin
      e.l = l && (k == eff - 1);
      e.d = 8'(w >> (8 * (3 - k)));
      q_m.push_back(e);
      e.d = 8'(w >> (8 * k));
      q_l.push_back(e);
    end
  endtask

  initial begin
    logic [31:0] seq;
    logic        exp_rdy, acc, xfer;

    vecs[0] = '{32'hA1B2C3D4, 3'd4, 1'b1, 4, 32'hA1B2C3D4, 32'hD4C3B2A1};
    vecs[1] = '{32'hA1B2C3D4, 3'd2, 1'b0, 2, 32'hA1B20000, 32'hD4C30000};
    vecs[2] = '{32'hCAFEF00D, 3'd0, 1'b1, 4, 32'hCAFEF00D, 32'h0DF0FECA};
    vecs[3] = '{32'h12345678, 3'd1, 1'b1, 1, 32'h12000000, 32'h78000000};
    vecs[4] = '{32'hDEADBEEF, 3'd3, 1'b1, 3, 32'hDEADBE00, 32'hEFBEAD00};
    vecs[5] = '{32'h0BADF00D, 3'd6, 1'b0, 4, 32'h0BADF00D, 32'h0DF0AD0B};

    rst = 1'b1; word = '0; nbytes = '0; last = 1'b0; word_valid = 1'b0; byte_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_valid", {val_m, val_l}, 2'b00);
    chk("reset_byte", {byte_m, byte_l}, 16'h0000);
    chk("reset_last", {lst_m, lst_l}, 2'b00);
    chk("reset_ready", {rdy_m, rdy_l}, 2'b00);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: second word accepted together with the final byte of the first.
    @(negedge clk);
    word = 32'h11223344; nbytes = 3'd4; last = 1'b0; word_valid = 1'b1; byte_ready = 1'b1;
    @(negedge clk);
    word = 32'h55667788;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) word_valid = 1'b0;
      #1;
      seq = 32'h11 * (k + 1);
      chk("b2b_valid", val_m, 1'b1);
      chk("b2b_byte", byte_m, seq[7:0]);
      chk("b2b_ready", rdy_m, (k == 3 || k == 7));
      @(negedge clk);
    end
    #1 chk("b2b_idle_after", val_m, 1'b0);

    // Backpressure holds the first lane.
    @(negedge clk);
    word = 32'hDEADBEEF; nbytes = 3'd4; last = 1'b0; word_valid = 1'b1; byte_ready = 1'b1;
    @(negedge clk);
    word_valid = 1'b0; byte_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_hold_byte", byte_m, 8'hDE);
      chk("bp_hold_valid", val_m, 1'b1);
      chk("bp_hold_ready", {rdy_m, rdy_l}, 2'b00);
      @(negedge clk);
    end
    byte_ready = 1'b1;
    seq = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_resume_byte", byte_m, seq[31:24]);
      seq = seq << 8;
      @(negedge clk);
    end

    // Reset after two of four bytes discards the rest.
    word = 32'hA1B2C3D4; nbytes = 3'd4; last = 1'b1; word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_mid_ready", rdy_m, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_mid_valid", {val_m, val_l}, 2'b00);
    chk("rst_mid_byte", {byte_m, byte_l}, 16'h0000);
    rst = 1'b0;
    word = 32'h01020304; nbytes = 3'd4; last = 1'b0; word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    seq = 32'h01020304;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_rst_valid", val_m, 1'b1);
      chk("post_rst_byte", byte_m, seq[31:24]);
      seq = seq << 8;
      @(negedge clk);
    end
    #1 chk("post_rst_idle", {val_m, val_l}, 2'b00);

    // Random traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 63) == 0);
      word       = $urandom;
      nbytes     = 3'($urandom_range(0, 7));
      last       = 1'($urandom);
      word_valid = ($urandom_range(0, 1) == 1);
      byte_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = !rst && (q_m.size() == 0 || (q_m.size() == 1 && byte_ready));
      chk("rnd_ready", {rdy_m, rdy_l}, {2{exp_rdy}});
      chk("rnd_valid", {val_m, val_l}, {2{q_m.size() != 0}});
      if (q_m.size() != 0 && val_m && val_l) begin
        chk("rnd_byte", {byte_m, byte_l}, {q_m[0].d, q_l[0].d});
        chk("rnd_last", {lst_m, lst_l}, {q_m[0].l, q_l[0].l});
      end
      acc  = word_valid && exp_rdy;
      xfer = !rst && (q_m.size() != 0) && byte_ready;
      @(posedge clk);
      if (rst) begin
        q_m.delete();
        q_l.delete();
      end else begin
        if (xfer) begin
          void'(q_m.pop_front());
          void'(q_l.pop_front());
        end
        if (acc) model_push(word, nbytes, last);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Unpacks words into a byte stream, one byte per handshake. It is the read-side counterpart of the byte-lane packing logic, which writes words with indexed part-selects.
- Byte order is selectable: MSB lane first (big-endian wire order) or LSB lane first.
- Supports partial words (1..NBYTES valid lanes) and a packet-last marker.
- Sits between the word-wide datapath and byte-wide link/UART-style consumers.

Parameters:
- WORD_W, 32: input word width; must be a multiple of 8 and at least 16.
- MSB_FIRST, 1: 1 = emit lanes from the most significant down; 0 = from the least significant up.
- Derived localparams (not overridable): NBYTES = WORD_W/8; CNT_W = clog2(NBYTES)+1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- word_i  in  WORD_W  input word.
- nbytes_i  in  CNT_W  number of valid lanes in word_i. Values 0 or >NBYTES are treated as NBYTES.
- last_i  in  1  word_i ends a packet.
- word_valid_i  in  1  word_i/nbytes_i/last_i are valid.
- word_ready_o  out  1  block accepts a word this cycle.
- byte_o  out  8  current output byte.
- byte_valid_o  out  1  byte_o is valid.
- byte_ready_i  in  1  consumer accepts byte_o this cycle.
- byte_last_o  out  1  byte_o is the final byte of a packet.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE; byte_valid_o=0, byte_o=0, byte_last_o=0.
  - Word register, lane count and lane index cleared.
  - word_ready_o=0 while rst_i is high.
  - Reset mid-word discards the remaining bytes; no partial output follows.
- States:
  - IDLE: no word held. word_ready_o=1.
  - SHIFT: word held; byte_valid_o=1.
- Word transfer: occurs when word_valid_i && word_ready_o at a clock edge.
  - Captures word_i, effective count nb, and last_i.
  - Sets idx=0 and moves to SHIFT.
  - First byte_valid_o appears the next cycle (latency 1).
- Byte transfer: occurs when byte_valid_o && byte_ready_i at a clock edge.
  - If idx < nb-1: idx increments.
  - If idx == nb-1 (final byte): the word is retired.
- Lane selection is combinational from registers only; byte_o must not depend combinationally on any input.
  - MSB_FIRST=1: byte_o = word[(NBYTES-1-idx)*8 +: 8]. Partial words are top-aligned; unused low lanes are ignored.
  - MSB_FIRST=0: byte_o = word[idx*8 +: 8]. Partial words are bottom-aligned.
- byte_last_o = held last flag AND idx==nb-1. It is 0 in IDLE.
- word_ready_o = IDLE, OR (SHIFT AND final byte being transferred this cycle). This allows back-to-back streaming with no bubble:
  - Simultaneous retire and accept: the new word is loaded, idx=0, state stays SHIFT.
  - Retire with no new word: state goes to IDLE and byte_valid_o drops next cycle.
- Backpressure: while byte_ready_i=0, byte_o, byte_last_o and idx hold stable. byte_valid_o never deasserts without a transfer.
- Throughput: sustained 1 byte/cycle with byte_ready_i=1. A full word takes NBYTES cycles.
- word_i changes while word_ready_o=0 are ignored.

Decomposition:
- Shared package (serdes_pkg):
  - BYTE_W=8.
  - A function computing lane offset from (idx, NBYTES, MSB_FIRST).
  - Nbytes-normalisation function (0/overflow -> NBYTES), reused by the matching packer.
- One small sub-module, lane_mux: a registered word plus index in, byte out. It holds the indexed part-select logic so the packer can share the same verified lane mapping.
- FSM, counter and handshake stay in byte_serializer.

Test Plan:
- MSB_FIRST=1, WORD_W=32, word 0xA1B2C3D4, nbytes=4, last=1, byte_ready_i=1 -> bytes A1,B2,C3,D4 on 4 consecutive cycles starting 1 cycle after accept; byte_last_o=1 only with D4.
- MSB_FIRST=0, same word, nbytes=2, last=0 -> bytes D4,C3; byte_last_o stays 0; word_ready_o=1 in the cycle C3 transfers.
- Back-to-back: words 0x11223344 and 0x55667788 both valid, nbytes=4, ready=1 -> 8 contiguous bytes 11..88 with no bubble; second accept coincides with byte 44.
- Backpressure: byte_ready_i=0 for 3 cycles after the first byte of 0xDEADBEEF (MSB_FIRST=1) -> byte_o holds DE, byte_valid_o stays 1, word_ready_o=0; sequence resumes AD,BE,EF.
- nbytes_i=0 with 0xCAFEF00D -> treated as 4 bytes: CA,FE,F0,0D.
- Reset asserted after 2 of 4 bytes -> next cycle byte_valid_o=0, byte_o=0; after release a new word 0x01020304 outputs 01 first with no stale bytes.
